inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Fetch stage directly upstream of the hart. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. It buffers one returned instruction with its PC and presents them to the hart through a valid/ready pair. It accepts redirects (branch/jump/trap targets) and discards any in-flight response belonging to the old path.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSN, 32'h0000_0013, value driven on insn when the buffer is invalid (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  read request valid
imem_addr  output  32  word address of request; bits [1:0] always 0
imem_gnt  input  1  memory accepts request this cycle (meaningful only with imem_req)
imem_rvalid  input  1  read data valid; earliest 1 cycle after grant
imem_rdata  input  32  instruction word
redirect  input  1  single-cycle pulse: restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
insn  output  32  buffered instruction to hart
pc  output  32  address of insn
insn_valid  output  1  insn/pc hold a valid instruction
insn_ready  input  1  hart consumes insn this cycle when insn_valid=1

Behaviour:
- Registers: fetch_pc (next address to request), req_pc (address of outstanding request), buffer {insn, pc, insn_valid}, FSM state.
- Reset (async, while asserted): state=REQ, fetch_pc=RESET_PC, req_pc=RESET_PC, insn_valid=0, insn=NOP_INSN, pc=RESET_PC, imem_req=0.
- At most one outstanding request. imem_req = (state==REQ) && !reset && (!insn_valid || insn_ready). imem_addr = fetch_pc.
- Consume: insn_valid && insn_ready clears insn_valid next cycle (unless refilled); insn returns to NOP_INSN when invalid.
- FSM states REQ, WAIT, DROP:
  REQ: on imem_req && imem_gnt -> WAIT; req_pc<=fetch_pc; fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  WAIT: on imem_rvalid -> REQ; insn<=imem_rdata, pc<=req_pc, insn_valid<=1.
  DROP: on imem_rvalid -> REQ; data discarded, buffer unchanged.
- Redirect (highest priority, any state): fetch_pc<={redirect_pc[31:2],2'b00}; insn_valid<=0; a consume in the same cycle is still a legal handshake.
  REQ without grant -> stay REQ; new address presented next cycle. Memory samples imem_addr only on grant cycles, so changing an ungranted request is legal.
  REQ with grant same cycle -> DROP; the granted request is orphaned and fetch_pc is not incremented.
  WAIT without rvalid -> DROP.
  WAIT with rvalid -> REQ; response discarded.
  DROP without rvalid -> stay DROP; fetch_pc updated.
  DROP with rvalid -> REQ.
- Buffer never overflows: a request issues only when the buffer is empty or being consumed, so the buffer is empty when the response lands.
- Throughput with 1-cycle memory and hart always ready: one instruction every 2 cycles. Latency from grant to insn_valid: rvalid latency + 1 cycle.
- Reset asserted mid-transaction: FSM returns to REQ; any later rvalid arriving while in REQ is ignored.
- imem_rvalid in REQ state is ignored.

Test Plan:
- Reset release, memory grants immediately and returns rdata=32'h00500093 one cycle later -> imem_addr=0x0 on first request; insn=0x00500093, pc=0x0, insn_valid=1 two cycles after grant; next request at 0x4.
- Hart holds insn_ready=0 for 5 cycles -> imem_req stays 0; insn/pc stable. Assert ready -> imem_req=1 with imem_addr=0x4 in that same cycle.
- Redirect to 0x0000_1002 while in WAIT (request to 0x8 outstanding), rvalid 2 cycles later -> response dropped, insn_valid stays 0; next imem_addr=0x1000; the delivered pc is 0x1000.
- Redirect coincident with grant of 0xC -> FSM in DROP; the later response for 0xC is discarded; next request goes to the redirect target.
- fetch_pc=0xFFFF_FFFC, granted -> next imem_addr=0x0000_0000.
- Reset pulsed while in WAIT, rvalid arrives after reset release -> response ignored; first request goes to RESET_PC; insn_valid=0, insn=NOP_INSN throughout.

Source files
------------

// File: rtl/inst_fetch.sv
// Fetch stage that issues one word read at a time and buffers one instruction for the hart.
// Redirects restart fetch and orphan any in-flight response from the old path.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        insn_valid,
  input  logic        insn_ready
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } state_e;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_ADDR = RESET_PC & WORD_MASK;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] pc_q, pc_d;
  logic        insn_valid_q, insn_valid_d;

  logic        granted;
  logic        consume;
  logic [31:0] redirect_target;

  assign imem_req        = (state_q == REQ) && !reset && (!insn_valid_q || insn_ready);
  assign imem_addr       = fetch_pc_q;
  assign granted         = imem_req && imem_gnt;
  assign consume         = insn_valid_q && insn_ready;
  assign redirect_target = redirect_pc & WORD_MASK;

  assign insn       = insn_q;
  assign pc         = pc_q;
  assign insn_valid = insn_valid_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    insn_d       = insn_q;
    pc_d         = pc_q;
    insn_valid_d = insn_valid_q;

    if (consume) begin
      insn_valid_d = 1'b0;
      insn_d       = NOP_INSN;
    end

    case (state_q)
      REQ: begin
        if (granted) begin
          state_d    = WAIT;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d      = REQ;
          insn_d       = imem_rdata;
          pc_d         = req_pc_q;
          insn_valid_d = 1'b1;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // A redirect overrides everything above: old-path data never reaches the buffer.
    if (redirect) begin
      fetch_pc_d   = redirect_target;
      insn_valid_d = 1'b0;
      insn_d       = NOP_INSN;
      pc_d         = pc_q;
      case (state_q)
        REQ:     state_d = granted ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= REQ;
      fetch_pc_q   <= RESET_ADDR;
      req_pc_q     <= RESET_ADDR;
      insn_q       <= NOP_INSN;
      pc_q         <= RESET_ADDR;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      insn_q       <= insn_d;
      pc_q         <= pc_d;
      insn_valid_q <= insn_valid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch with a transaction-level reference model and a
// latency-randomizing instruction memory.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        insn_valid;
  logic        insn_ready;

  int check_count;
  int fail_count;

  // Reference model: next fetch address, one outstanding read, one-entry buffer.
  logic [31:0] m_fetch;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_out_addr;
  logic        m_bvalid;
  logic [31:0] m_binsn;
  logic [31:0] m_bpc;

  // Memory: at most one pending response, delivered after a random latency.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_cnt;

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .NOP_INSN(NOP_INSN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .insn(insn),
    .pc(pc),
    .insn_valid(insn_valid),
    .insn_ready(insn_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_fetch  = RESET_PC;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_out_addr = RESET_PC;
    m_bvalid = 1'b0;
    m_binsn  = NOP_INSN;
    m_bpc    = RESET_PC;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    checkOutput({tag, "_addr"}, imem_addr, RESET_PC);
    checkOutput({tag, "_valid"}, {31'd0, insn_valid}, 32'd0);
    checkOutput({tag, "_insn"}, insn, NOP_INSN);
    checkOutput({tag, "_pc"}, pc, RESET_PC);
  endtask

  // Reset pulse asserted between clock edges; a pending memory response survives it.
  task automatic resetDut();
    @(negedge clk);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    insn_ready  = 1'b0;
    #2 reset = 1'b1;
    #1 checkResetState("rst_async");
    @(negedge clk);
    #1 checkResetState("rst_hold");
    reset = 1'b0;
    modelReset();
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance model and memory.
  task automatic applyStimulus(input logic rdy, input logic rd, input logic [31:0] rpc,
                               input logic gnt, input int lat, input logic spur);
    logic        exp_req;
    logic        consume;
    logic        granted;
    logic        resp;
    logic        dut_grant;
    logic [31:0] grant_addr;
    @(negedge clk);
    insn_ready  = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = gnt && !mem_pend;
    imem_rvalid = (mem_pend && mem_cnt == 0) || (!mem_pend && spur);
    imem_rdata  = (mem_pend && mem_cnt == 0) ? mem_word(mem_addr) : $urandom;
    #1;
    exp_req = !m_out && (!m_bvalid || rdy);
    checkOutput("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    checkOutput("imem_addr", imem_addr, m_fetch);
    checkOutput("insn_valid", {31'd0, insn_valid}, {31'd0, m_bvalid});
    checkOutput("insn", insn, m_bvalid ? m_binsn : NOP_INSN);
    checkOutput("pc", pc, m_bpc);

    consume = m_bvalid && rdy;
    granted = exp_req && imem_gnt;
    resp    = m_out && imem_rvalid;
    if (consume) m_bvalid = 1'b0;
    if (resp) begin
      m_out = 1'b0;
      if (!m_stale && !rd) begin
        m_bvalid = 1'b1;
        m_binsn  = imem_rdata;
        m_bpc    = m_out_addr;
      end
    end
    if (granted) begin
      m_out      = 1'b1;
      m_out_addr = m_fetch;
      m_stale    = rd;
      if (!rd) m_fetch = m_fetch + 32'd4;
    end
    if (rd) begin
      m_fetch  = {rpc[31:2], 2'b00};
      m_bvalid = 1'b0;
      m_stale  = 1'b1;
    end

    dut_grant  = imem_req && imem_gnt;
    grant_addr = imem_addr;
    if (mem_pend && imem_rvalid) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (dut_grant) begin
      mem_pend = 1'b1;
      mem_addr = grant_addr;
      mem_cnt  = lat - 1;
    end
  endtask

  initial begin
    logic [31:0] rpc;
    check_count = 0;
    fail_count  = 0;
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    insn_ready  = 1'b0;
    mem_pend    = 1'b0;
    mem_addr    = 32'h0;
    mem_cnt     = 0;
    modelReset();
    resetDut();

    // First fetch from RESET_PC with a one-cycle memory.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("first_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    // Hart stalls for five cycles: no request, buffer stable.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      checkOutput("stall_req", {31'd0, imem_req}, 32'd0);
      checkOutput("stall_insn", insn, 32'h0050_0093);
      checkOutput("stall_pc", pc, 32'h0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 2, 1'b0);
    checkOutput("ready_req", {31'd0, imem_req}, 32'd1);
    checkOutput("ready_addr", imem_addr, 32'h4);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b0);
    // Request to 0x8 granted with latency 3, then redirected while waiting.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b0);
    checkOutput("wait_grant_addr", imem_addr, 32'h8);
    applyStimulus(1'b1, 1'b1, 32'h0000_1002, 1'b1, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("redir_addr", imem_addr, 32'h1000);
    checkOutput("redir_req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    // Redirect coincident with a grant, then a word-aligned wrap at the top of memory.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 1'b1, 2, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("wrap_top", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
    checkOutput("wrap_zero", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 3, 1'b0);
    // Reset while a slow response is outstanding; it lands later and must be ignored.
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
      checkOutput("post_rst_valid", {31'd0, insn_valid}, 32'd0);
      checkOutput("post_rst_insn", insn, NOP_INSN);
    end

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299, 0) == 0) resetDut();
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      applyStimulus($urandom_range(9, 0) < 7, $urandom_range(9, 0) == 0, rpc,
                    $urandom_range(9, 0) < 7, int'($urandom_range(3, 1)),
                    $urandom_range(9, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
